// File: rtl/io_port_unit.sv
// I/O and software-interrupt responder for the ERM16 core: latched OUT ports,
// handshaked IN ports, a status word and a small interrupt-vector FIFO.
module io_port_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int NOUT      = 4,
  parameter int NIN       = 4,
  parameter int IRQ_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   init_n,
  input  logic                   ioe,
  input  logic                   io_wr,
  input  logic [ADDR_W-1:0]      io_addr,
  input  logic [DATA_W-1:0]      io_wdata,
  output logic [DATA_W-1:0]      io_rdata,
  input  logic                   intreq,
  output logic [NOUT*DATA_W-1:0] out_port,
  output logic [NOUT-1:0]        out_stb,
  input  logic [NIN*DATA_W-1:0]  in_port,
  input  logic [NIN-1:0]         in_valid,
  output logic [NIN-1:0]         in_ack,
  output logic                   irq,
  output logic [ADDR_W-1:0]      irq_num,
  input  logic                   irq_ack
);

  localparam int PTR_W = (IRQ_DEPTH > 1) ? $clog2(IRQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(IRQ_DEPTH);
  localparam logic [ADDR_W-1:0] IN_BASE   = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(14);

  logic [DATA_W-1:0]      io_rdata_r, rdata_nxt_s;
  logic [NOUT*DATA_W-1:0] out_port_r, out_nxt_s;
  logic [NOUT-1:0]        out_stb_r, stb_nxt_s;
  logic [NIN-1:0]         in_ack_r, ack_nxt_s;
  logic                   irq_r, irq_nxt_s;
  logic [ADDR_W-1:0]      irq_num_r, irq_num_nxt_s;
  logic [ADDR_W-1:0]      fifo_mem_r [IRQ_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  logic                   ovf_r, ovf_nxt_s;
  logic                   full_s, pop_s, push_s, drop_s, stat_rd_s;
  logic [DATA_W-1:0]      stat_s;

  // CPU port access decode: OUT latches/strobes, IN read mux and input acks
  always_comb begin
    rdata_nxt_s = io_rdata_r;
    out_nxt_s   = out_port_r;
    stb_nxt_s   = '0;
    ack_nxt_s   = '0;
    stat_rd_s   = 1'b0;
    stat_s      = '0;
    stat_s[NIN-1:0] = in_valid;
    stat_s[13]  = full_s;
    stat_s[14]  = ovf_r;
    stat_s[15]  = irq_r;
    if (ioe) begin
      if (io_wr) begin
        for (int k = 0; k < NOUT; k++) begin
          if (io_addr == ADDR_W'(k)) begin
            out_nxt_s[k*DATA_W +: DATA_W] = io_wdata;
            stb_nxt_s[k] = 1'b1;
          end else begin
          end
        end
      end else begin
        // unmapped reads return zero unless one of the matches below fires
        rdata_nxt_s = '0;
        for (int k = 0; k < NOUT; k++) begin
          if (io_addr == ADDR_W'(k)) begin
            rdata_nxt_s = out_port_r[k*DATA_W +: DATA_W];
          end else begin
          end
        end
        for (int j = 0; j < NIN; j++) begin
          if (io_addr == IN_BASE + ADDR_W'(j) && in_valid[j]) begin
            rdata_nxt_s  = in_port[j*DATA_W +: DATA_W];
            ack_nxt_s[j] = 1'b1;
          end else begin
          end
        end
        if (io_addr == STAT_ADDR) begin
          rdata_nxt_s = stat_s;
          stat_rd_s   = 1'b1;
        end else begin
        end
      end
    end else begin
    end
  end

  // Interrupt FIFO next state; a pop on a full FIFO frees room for a same-cycle push
  always_comb begin
    full_s    = (cnt_r == FULL_CNT);
    pop_s     = irq_ack && (cnt_r != {CNT_W{1'b0}});
    push_s    = intreq && (!full_s || pop_s);
    drop_s    = intreq && full_s && !pop_s;
    wr_nxt_s  = push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
    rd_nxt_s  = pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
    ovf_nxt_s = (ovf_r && !stat_rd_s) || drop_s;
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
      2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
    irq_nxt_s = (cnt_nxt_s != {CNT_W{1'b0}});
    // the new head may be the vector being written this very cycle
    if (!irq_nxt_s) begin
      irq_num_nxt_s = '0;
    end else if (push_s && rd_nxt_s == wr_ptr_r) begin
      irq_num_nxt_s = io_addr;
    end else begin
      irq_num_nxt_s = fifo_mem_r[rd_nxt_s];
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      io_rdata_r <= '0;
      out_port_r <= '0;
      out_stb_r  <= '0;
      in_ack_r   <= '0;
      irq_r      <= 1'b0;
      irq_num_r  <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      cnt_r      <= '0;
      ovf_r      <= 1'b0;
      for (int i = 0; i < IRQ_DEPTH; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else begin
      io_rdata_r <= rdata_nxt_s;
      out_port_r <= out_nxt_s;
      out_stb_r  <= stb_nxt_s;
      in_ack_r   <= ack_nxt_s;
      irq_r      <= irq_nxt_s;
      irq_num_r  <= irq_num_nxt_s;
      wr_ptr_r   <= wr_nxt_s;
      rd_ptr_r   <= rd_nxt_s;
      cnt_r      <= cnt_nxt_s;
      ovf_r      <= ovf_nxt_s;
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= io_addr;
      end
    end
  end

  assign io_rdata = io_rdata_r;
  assign out_port = out_port_r;
  assign out_stb  = out_stb_r;
  assign in_ack   = in_ack_r;
  assign irq      = irq_r;
  assign irq_num  = irq_num_r;

endmodule

// File: tb/tb_io_port_unit.sv
// Self-checking bench for io_port_unit: directed scenarios followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_io_port_unit;

  logic        clk;
  logic        init_n;
  logic        ioe;
  logic        io_wr;
  logic [3:0]  io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        intreq;
  logic [63:0] out_port;
  logic [3:0]  out_stb;
  logic [63:0] in_port;
  logic [3:0]  in_valid;
  logic [3:0]  in_ack;
  logic        irq;
  logic [3:0]  irq_num;
  logic        irq_ack;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [15:0] m_out [4];
  logic [15:0] m_rdata;
  logic [3:0]  m_stb;
  logic [3:0]  m_ack;
  logic        m_ovf;
  logic [3:0]  q[$];

  io_port_unit dut (
    .clk(clk), .init_n(init_n), .ioe(ioe), .io_wr(io_wr), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .intreq(intreq),
    .out_port(out_port), .out_stb(out_stb), .in_port(in_port),
    .in_valid(in_valid), .in_ack(in_ack), .irq(irq), .irq_num(irq_num),
    .irq_ack(irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_out[i] = 16'h0;
    m_rdata = 16'h0;
    m_stb   = 4'h0;
    m_ack   = 4'h0;
    m_ovf   = 1'b0;
    q.delete();
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":out_port"}, out_port, {m_out[3], m_out[2], m_out[1], m_out[0]});
    chk({ctx, ":out_stb"}, {60'h0, out_stb}, {60'h0, m_stb});
    chk({ctx, ":in_ack"}, {60'h0, in_ack}, {60'h0, m_ack});
    chk({ctx, ":io_rdata"}, {48'h0, io_rdata}, {48'h0, m_rdata});
    chk({ctx, ":irq"}, {63'h0, irq}, {63'h0, (q.size() != 0)});
    chk({ctx, ":irq_num"}, {60'h0, irq_num}, {60'h0, (q.size() != 0) ? q[0] : 4'h0});
  endtask

  // one clock of stimulus; called just after a rising edge
  task automatic cyc(input logic e, input logic w, input logic [3:0] a,
                     input logic [15:0] d, input logic iq, input logic ak,
                     input string ctx);
    logic [15:0] st;
    int ai;
    bit pop;
    ioe = e; io_wr = w; io_addr = a; io_wdata = d; intreq = iq; irq_ack = ak;
    ai = int'(a);
    m_stb = 4'h0;
    m_ack = 4'h0;
    st = 16'h0;
    st[3:0] = in_valid;
    st[13]  = (q.size() == 4);
    st[14]  = m_ovf;
    st[15]  = (q.size() != 0);
    if (e) begin
      if (w) begin
        if (ai < 4) begin
          m_out[ai] = d;
          m_stb[ai] = 1'b1;
        end
      end else begin
        if (ai < 4) m_rdata = m_out[ai];
        else if (ai >= 8 && ai < 12) begin
          if (in_valid[ai-8]) begin
            m_rdata = in_port[(ai-8)*16 +: 16];
            m_ack[ai-8] = 1'b1;
          end else m_rdata = 16'h0;
        end else if (ai == 14) begin
          m_rdata = st;
          m_ovf = 1'b0;
        end else m_rdata = 16'h0;
      end
    end
    pop = ak && (q.size() > 0);
    if (iq && q.size() == 4 && !pop) m_ovf = 1'b1;
    if (pop) void'(q.pop_front());
    if (iq && q.size() < 4) q.push_back(a);
    @(posedge clk);
    #1;
    ioe = 1'b0; io_wr = 1'b0; intreq = 1'b0; irq_ack = 1'b0;
    check_all(ctx);
  endtask

  initial begin
    init_n = 1'b0;
    ioe = 1'b1; io_wr = 1'b0; io_addr = 4'd3; io_wdata = 16'hFFFF;
    intreq = 1'b1; irq_ack = 1'b0;
    in_port = 64'h0; in_valid = 4'h0;
    model_reset();

    // reset holds everything at zero despite active strobes
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_port", out_port, 64'h0);
    chk("rst_out_stb", {60'h0, out_stb}, 64'h0);
    chk("rst_in_ack", {60'h0, in_ack}, 64'h0);
    chk("rst_rdata", {48'h0, io_rdata}, 64'h0);
    chk("rst_irq", {63'h0, irq}, 64'h0);
    chk("rst_irq_num", {60'h0, irq_num}, 64'h0);
    ioe = 1'b0; intreq = 1'b0;
    init_n = 1'b1;

    cyc(1'b1, 1'b0, 4'd14, 16'h0, 1'b0, 1'b0, "stat_after_rst");
    chk("stat_zero", {48'h0, io_rdata}, 64'h0);

    // OUT and readback
    cyc(1'b1, 1'b1, 4'd2, 16'hBEEF, 1'b0, 1'b0, "out2");
    chk("out2_stb", {60'h0, out_stb}, 64'h4);
    chk("out2_val", {48'h0, out_port[47:32]}, 64'hBEEF);
    cyc(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, "idle1");
    cyc(1'b1, 1'b0, 4'd2, 16'h0, 1'b0, 1'b0, "in2");
    chk("in2_val", {48'h0, io_rdata}, 64'hBEEF);
    cyc(1'b1, 1'b1, 4'd5, 16'h5555, 1'b0, 1'b0, "out5");

    // input handshake and back-to-back access
    in_valid = 4'b0010;
    in_port[31:16] = 16'h1234;
    cyc(1'b1, 1'b0, 4'd9, 16'h0, 1'b0, 1'b0, "in9");
    chk("in9_val", {48'h0, io_rdata}, 64'h1234);
    chk("in9_ack", {60'h0, in_ack}, 64'h2);
    cyc(1'b1, 1'b0, 4'd14, 16'h0, 1'b0, 1'b0, "b2b_stat");
    chk("b2b_stat_val", {48'h0, io_rdata}, 64'h0002);
    in_valid = 4'b0000;
    cyc(1'b1, 1'b0, 4'd9, 16'h0, 1'b0, 1'b0, "in9_invalid");

    // fill the FIFO, overflow, sticky clear on read
    in_valid = 4'b0101;
    cyc(1'b0, 1'b0, 4'd3, 16'h0, 1'b1, 1'b0, "int3");
    cyc(1'b0, 1'b0, 4'd7, 16'h0, 1'b1, 1'b0, "int7");
    cyc(1'b0, 1'b0, 4'd1, 16'h0, 1'b1, 1'b0, "int1");
    cyc(1'b0, 1'b0, 4'd9, 16'h0, 1'b1, 1'b0, "int9");
    chk("fifo_head", {60'h0, irq_num}, 64'h3);
    cyc(1'b1, 1'b0, 4'd14, 16'h0, 1'b0, 1'b0, "stat_full");
    chk("stat_full_val", {48'h0, io_rdata}, 64'hA005);
    cyc(1'b0, 1'b0, 4'd4, 16'h0, 1'b1, 1'b0, "int4_drop");
    cyc(1'b1, 1'b0, 4'd14, 16'h0, 1'b0, 1'b0, "stat_ovf");
    chk("stat_ovf_val", {48'h0, io_rdata}, 64'hE005);
    cyc(1'b1, 1'b0, 4'd14, 16'h0, 1'b0, 1'b0, "stat_ovf_clr");
    chk("stat_ovf_clr_val", {48'h0, io_rdata}, 64'hA005);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1, "ack_drain");
    chk("drained_irq", {63'h0, irq}, 64'h0);

    // drop and status read in the same cycle: read sees old flag, flag ends set
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'(i + 10), 16'h0, 1'b1, 1'b0, "fill");
    cyc(1'b1, 1'b0, 4'd14, 16'h0, 1'b1, 1'b0, "drop_and_read");
    chk("drop_read_old", {48'h0, io_rdata}, 64'hA005);
    cyc(1'b1, 1'b0, 4'd14, 16'h0, 1'b0, 1'b0, "drop_read_after");
    chk("drop_read_new", {48'h0, io_rdata}, 64'hE005);

    // full FIFO, simultaneous push and pop
    cyc(1'b0, 1'b0, 4'd6, 16'h0, 1'b1, 1'b1, "push_pop_full");
    cyc(1'b1, 1'b0, 4'd14, 16'h0, 1'b0, 1'b0, "stat_no_ovf");
    chk("no_ovf_val", {48'h0, io_rdata}, 64'hA005);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1, "ack3");
    chk("last_is_6", {60'h0, irq_num}, 64'h6);
    // push and ack on empty: ack ignored
    cyc(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1, "ack_last");
    cyc(1'b0, 1'b0, 4'd8, 16'h0, 1'b1, 1'b1, "push_pop_empty");
    cyc(1'b0, 1'b0, 4'd2, 16'h0, 1'b1, 1'b0, "int2");

    // asynchronous reset mid-operation
    init_n = 1'b0;
    #2;
    chk("async_irq", {63'h0, irq}, 64'h0);
    chk("async_out_port", out_port, 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    init_n = 1'b1;
    cyc(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, "post_rst");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) in_valid = 4'($urandom);
      if ($urandom_range(0, 3) == 0) in_port = {$urandom, $urandom};
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
          16'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
          "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_unit.md
# io_port_unit

I/O and software-interrupt responder for the ERM16 core. It services the control unit's one-cycle `ioe` strobe for IN/OUT and its one-cycle `intreq` strobe for INT. It sits between the core datapath and external peripherals, providing latched output ports, handshaked input ports, a status register, and a 4-entry interrupt vector FIFO toward the external interrupt handler.

## Interface
- `DATA_W`, 16: I/O data width.
- `ADDR_W`, 4: port address width (16 port addresses).
- `NOUT`, 4: output ports, at addresses 0..NOUT-1.
- `NIN`, 4: input ports, at addresses 8..8+NIN-1.
- `IRQ_DEPTH`, 4: interrupt FIFO depth (power of two).

Ports:
- `clk` in 1: clock; all state changes on rising edge.
- `init_n` in 1: asynchronous, active-low reset.
- `ioe` in 1: CPU I/O strobe, one cycle per access.
- `io_wr` in 1: direction qualified by `ioe`; 1 = OUT, 0 = IN.
- `io_addr` in ADDR_W: port address; also the vector source for INT.
- `io_wdata` in DATA_W: OUT write data.
- `io_rdata` out DATA_W: IN read data, registered and held.
- `intreq` in 1: software-interrupt strobe, one cycle.
- `out_port` out NOUT*DATA_W: packed output-port latches; port k occupies bits [k*DATA_W +: DATA_W].
- `out_stb` out NOUT: one-cycle pulse when port k is written.
- `in_port` in NIN*DATA_W: packed input-port data, held by the peripheral while its valid is high.
- `in_valid` in NIN: input port k has data.
- `in_ack` out NIN: one-cycle pulse; port k data consumed.
- `irq` out 1: interrupt FIFO not empty.
- `irq_num` out ADDR_W: vector at FIFO head.
- `irq_ack` in 1: pops the FIFO head.

## Operation

**Reset.** `io_rdata`=0, `out_port`=0, `out_stb`=0, `in_ack`=0, `irq`=0, `irq_num`=0. FIFO is empty, overflow flag is 0.

**OUT** (`ioe`=1, `io_wr`=1):
- addr k < NOUT: `out_port[k]` <= `io_wdata`; `out_stb[k]` pulses.
- Any other address: ignored, no strobe.

**IN** (`ioe`=1, `io_wr`=0); `io_rdata` is loaded as follows:
- addr k < NOUT: read back `out_port[k]`.
- addr 8+j, j < NIN, with `in_valid[j]`=1: load `in_port[j]` and pulse `in_ack[j]`.
- addr 8+j with `in_valid[j]`=0: load 0, no ack.
- addr 14 (status):
  - bits [NIN-1:0] = `in_valid`.
  - bit 13 = FIFO full.
  - bit 14 = overflow.
  - bit 15 = `irq`.
  - other bits 0.
  - The read clears overflow.
- Unmapped addresses: load 0.

**INT** (`intreq`=1): push `io_addr` into the FIFO.
- FIFO full without a same-cycle pop: the vector is dropped and overflow is set (sticky).

**FIFO.**
- `irq` = not empty; `irq_num` = head entry, or 0 when empty.
- `irq_ack` pops the head; `irq_ack` while empty is ignored.
- Same-cycle push and pop:
  - FIFO not empty: both happen; occupancy is unchanged.
  - FIFO empty: the push happens; the ack is ignored.
  - FIFO full: the pop happens and the push is accepted; no overflow.
- Pointers wrap modulo IRQ_DEPTH. The occupancy counter is ADDR-independent and sized log2(IRQ_DEPTH)+1 bits.

**Concurrency.**
- `ioe` and `intreq` in the same cycle are both serviced.
- Overflow set (drop) and a status read in the same cycle: the read returns the old value and overflow ends at 1.

## Timing
- OUT in cycle N: `out_port[k]` is new from N+1; `out_stb[k]` is high in N+1 only.
- IN in cycle N: `io_rdata` is valid from N+1 and held until the next IN access. This matches the core writing back in the cycle after the `ioe` cycle.
- `in_ack[j]` is high in N+1 only. The peripheral may drop `in_valid` or change data from N+2.
- Back-to-back `ioe` on consecutive cycles is fully supported; each access produces its own response one cycle later.
- `intreq` in cycle N: the entry is visible from N+1, so `irq` rises in N+1 if the FIFO was empty.
- `irq_ack` in cycle M: `irq_num` shows the next entry (or `irq`=0) from M+1.
- `init_n` low mid-operation: all state and outputs return to reset values immediately (asynchronous). Pending strobes and FIFO contents are lost.

## Test plan
- **Reset:** hold `init_n`=0, drive `ioe`/`intreq` -> all outputs 0. Release; IN addr 14 -> `io_rdata`=0x0000.
- **OUT/readback:**
  - OUT addr 2, data 0xBEEF in cycle N -> `out_port[2]`=0xBEEF and `out_stb`=4'b0100 in N+1 only.
  - IN addr 2 -> `io_rdata`=0xBEEF next cycle.
  - OUT addr 5 -> no strobe, no change.
- **Input handshake:**
  - `in_valid[1]`=1, `in_port[1]`=0x1234, IN addr 9 -> `io_rdata`=0x1234 and `in_ack`=4'b0010 for one cycle.
  - With `in_valid[1]`=0 -> `io_rdata`=0, no ack.
- **Back-to-back:** IN addr 9 then IN addr 14 on consecutive cycles -> `io_rdata` is 0x1234, then the status word, on successive cycles.
- **IRQ FIFO:**
  - `intreq` with `io_addr` 3, 7, 1, 9 -> `irq`=1, `irq_num`=3; status bit 13=1.
  - Fifth `intreq` (addr 4) -> dropped; status read = 0xE000 | `in_valid`; the following status read has bit 14=0.
  - `irq_ack` x4 -> `irq_num` sequence 7, 1, 9, then `irq`=0.
- **Simultaneous:**
  - Full FIFO, `intreq`(addr 6) + `irq_ack` in the same cycle -> no overflow; the last entry is 6.
  - `init_n` pulse while non-empty -> `irq`=0 immediately.
